// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Turns a stream of decoded-operation descriptors (class, aluop, rd, rs1,
//   rs2, imm) back into 32-bit RV instruction words and writes them
//   sequentially into instruction memory, starting at a host-supplied base
//   byte address. Uses the same aluop codes as the core's decode path.
//   Descriptors that cannot be encoded still consume a slot and are written
//   as a NOP (addi x0,x0,0) while err/err_count record the event.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle load request, only honoured in IDLE
//   base_addr       first write byte address (word aligned)
//   length          number of instructions in the program
//   busy            high while a load is in progress (RUN)
//   done            one-cycle completion pulse
//   in_valid/ready  descriptor handshake
//   in_class        0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 BRANCH, 5 XORACC
//   in_aluop        ALU code; BRANCH uses [1:0] as BEQ/BNE/BLT/BGE
//   in_rd/rs1/rs2   register indices
//   in_imm          signed immediate
//   imem_we/addr/wdata  instruction memory write port
//   err             sticky illegal-descriptor flag, cleared by start
//   err_count       illegal descriptors in the current load
//   wr_count        words written in the current load
//
// FSM states:
//   state    | meaning
//   ST_IDLE  | waiting for start; zero-length start pulses done here
//   ST_RUN   | accepting descriptors while remaining != 0; leaves one
//            | cycle after the final accept (the done/write cycle)
// ----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [3:0]        in_aluop,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err,
    output logic [LEN_W-1:0]  err_count,
    output logic [LEN_W-1:0]  wr_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] CLS_RTYPE  = 3'd0;
    localparam logic [2:0] CLS_ITYPE  = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_XORACC = 3'd5;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_XORACC = 7'b1110011;

    localparam logic [31:0]       NOP_WORD = 32'h0000_0013;
    localparam logic [LEN_W-1:0]  CNT_MAX  = '1;
    localparam logic [LEN_W-1:0]  CNT_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(4);

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  remaining;
    logic              we_q;
    logic              done_q;
    logic              accept;

    logic signed [31:0] imm_s;
    logic               imm12_ok;
    logic               shamt_ok;
    logic               br_ok;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               enc_ok;
    logic [31:0]        enc_word;

    // Write strobe, done and ready are masked by rst so that a reset cycle
    // never shows a write or a completion, even one already registered.
    assign busy     = (state == ST_RUN);
    assign in_ready = busy && (remaining != '0) && !rst;
    assign imem_we  = we_q && !rst;
    assign done     = done_q && !rst;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Immediate range checks
    // ------------------------------------------------------------------
    assign imm_s    = $signed(in_imm);
    assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign shamt_ok = (imm_s >= 32'sd0) && (imm_s <= 32'sd63);
    assign br_ok    = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    always_comb begin
        f3       = 3'b000;
        f7       = 7'b0000000;
        enc_ok   = 1'b0;
        enc_word = NOP_WORD;
        case (in_class)
            CLS_RTYPE: begin
                enc_ok = 1'b1;
                case (in_aluop)
                    4'd1:    f3 = 3'b000;
                    4'd2:    f7 = 7'b0100000;
                    4'd6:    f3 = 3'b001;
                    4'd8:    f3 = 3'b010;
                    4'd9:    f3 = 3'b011;
                    4'd5:    f3 = 3'b100;
                    4'd7:    f3 = 3'b101;
                    4'd4:    f3 = 3'b110;
                    4'd3:    f3 = 3'b111;
                    default: enc_ok = 1'b0;
                endcase
                enc_word = {f7, in_rs2, in_rs1, f3, in_rd, OP_RTYPE};
            end
            CLS_ITYPE: begin
                // Shifts carry a 6-bit shamt in imm[5:0]; upper imm bits
                // (funct6) stay zero because the range check forbids them.
                enc_ok = imm12_ok;
                case (in_aluop)
                    4'd1: f3 = 3'b000;
                    4'd6: begin
                        f3     = 3'b001;
                        enc_ok = shamt_ok;
                    end
                    4'd5: f3 = 3'b100;
                    4'd7: begin
                        f3     = 3'b101;
                        enc_ok = shamt_ok;
                    end
                    default: enc_ok = 1'b0;
                endcase
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd, OP_ITYPE};
            end
            CLS_LOAD: begin
                enc_ok   = imm12_ok;
                enc_word = {in_imm[11:0], in_rs1, 3'b011, in_rd, OP_LOAD};
            end
            CLS_STORE: begin
                enc_ok   = imm12_ok;
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b011, in_imm[4:0], OP_STORE};
            end
            CLS_BRANCH: begin
                enc_ok = br_ok;
                case (in_aluop[1:0])
                    2'd0:    f3 = 3'b000;
                    2'd1:    f3 = 3'b001;
                    2'd2:    f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                            in_imm[4:1], in_imm[11], OP_BRANCH};
            end
            CLS_XORACC: begin
                enc_ok   = 1'b1;
                enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OP_XORACC};
            end
            default: enc_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            remaining  <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            err_count  <= '0;
            wr_count   <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err       <= 1'b0;
                        err_count <= '0;
                        wr_count  <= '0;
                        if (length != '0) begin
                            ptr       <= base_addr;
                            remaining <= length;
                            state     <= ST_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        we_q       <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= enc_ok ? enc_word : NOP_WORD;
                        ptr        <= ptr + WORD_INC;
                        remaining  <= remaining - CNT_ONE;
                        if (wr_count != CNT_MAX) begin
                            wr_count <= wr_count + CNT_ONE;
                        end
                        if (!enc_ok) begin
                            err <= 1'b1;
                            if (err_count != CNT_MAX) begin
                                err_count <= err_count + CNT_ONE;
                            end
                        end
                        // Final accept: done rides along with the last write.
                        if (remaining == CNT_ONE) begin
                            done_q <= 1'b1;
                        end
                    end else if (remaining == '0) begin
                        // Stay one extra cycle so busy covers the done cycle.
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: table of descriptors with hand-encoded
// words, streamed through generic loads, plus hand-written sequences for
// gaps, start-during-run, zero length and reset mid-load.
module tb_instr_encoder_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [3:0]  in_aluop;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        err;
    logic [7:0]  err_count;
    logic [7:0]  wr_count;

    int errors = 0;
    int checks = 0;

    instr_encoder_loader #(.ADDR_W(10), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_aluop   (in_aluop),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .err        (err),
        .err_count  (err_count),
        .wr_count   (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0]  cls;
        logic [3:0]  aluop;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        bad;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int idx);
        in_class = vecs[idx].cls;
        in_aluop = vecs[idx].aluop;
        in_rd    = vecs[idx].rd;
        in_rs1   = vecs[idx].rs1;
        in_rs2   = vecs[idx].rs2;
        in_imm   = vecs[idx].imm;
        in_valid = 1'b1;
    endtask

    task automatic do_start(input logic [9:0] base, input logic [7:0] len);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        length    = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams vecs[first .. first+n-1] back-to-back and checks every write.
    task automatic run_load(input logic [9:0] base, input int first, input int n, input int exp_err);
        logic [9:0] a;
        a = base;
        do_start(base, n[7:0]);
        chk("busy_in_run", busy, 1);
        chk("err_cleared_by_start", err, 0);
        chk("wr_count_cleared", wr_count, 0);
        for (int i = 0; i < n; i++) begin
            drive(first + i);
            chk("in_ready_run", in_ready, 1);
            @(posedge clk); #1;
            chk($sformatf("we_v%0d", first + i), imem_we, 1);
            chk($sformatf("addr_v%0d", first + i), imem_addr, a);
            chk($sformatf("data_v%0d", first + i), imem_wdata, vecs[first + i].word);
            chk($sformatf("done_v%0d", first + i), done, (i == n - 1));
            a = a + 10'd4;
        end
        in_valid = 1'b0;
        chk("in_ready_after_last", in_ready, 0);
        chk("busy_in_done_cycle", busy, 1);
        chk("wr_count_final", wr_count, n);
        chk("err_count_final", err_count, exp_err);
        chk("err_final", err, (exp_err != 0));
        @(posedge clk); #1;
        chk("busy_after_done", busy, 0);
        chk("we_after_done", imem_we, 0);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        //          cls   aluop rd     rs1    rs2    imm            word            bad
        vecs[0]  = '{3'd0, 4'd1, 5'd3,  5'd1,  5'd2,  32'd0,         32'h002081B3, 1'b0}; // ADD x3,x1,x2
        vecs[1]  = '{3'd0, 4'd2, 5'd5,  5'd6,  5'd7,  32'd0,         32'h407302B3, 1'b0}; // SUB x5,x6,x7
        vecs[2]  = '{3'd1, 4'd1, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFF,  32'hFFF00093, 1'b0}; // ADDI x1,x0,-1
        vecs[3]  = '{3'd3, 4'd0, 5'd0,  5'd1,  5'd2,  32'd8,         32'h0020B423, 1'b0}; // SD x2,8(x1)
        vecs[4]  = '{3'd5, 4'd0, 5'd4,  5'd1,  5'd2,  32'd0,         32'h00208273, 1'b0}; // XORACC x4,x1,x2
        vecs[5]  = '{3'd1, 4'd1, 5'd1,  5'd0,  5'd0,  32'd2048,      32'h00000013, 1'b1}; // ADDI imm too big
        vecs[6]  = '{3'd4, 4'd0, 5'd0,  5'd1,  5'd2,  32'd3,         32'h00000013, 1'b1}; // BRANCH odd imm
        vecs[7]  = '{3'd7, 4'd0, 5'd1,  5'd1,  5'd1,  32'd0,         32'h00000013, 1'b1}; // class 7
        vecs[8]  = '{3'd4, 4'd0, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC,  32'hFE208EE3, 1'b0}; // BEQ x1,x2,-4
        vecs[9]  = '{3'd4, 4'd3, 5'd0,  5'd1,  5'd2,  32'd8,         32'h0020D463, 1'b0}; // BGE x1,x2,8
        vecs[10] = '{3'd0, 4'd3, 5'd10, 5'd11, 5'd12, 32'd0,         32'h00C5F533, 1'b0}; // AND x10,x11,x12
        vecs[11] = '{3'd1, 4'd6, 5'd1,  5'd2,  5'd0,  32'd63,        32'h03F11093, 1'b0}; // SLLI x1,x2,63
        vecs[12] = '{3'd1, 4'd6, 5'd1,  5'd2,  5'd0,  32'd64,        32'h00000013, 1'b1}; // SLLI 64
        vecs[13] = '{3'd2, 4'd0, 5'd5,  5'd6,  5'd0,  32'hFFFFF800,  32'h80033283, 1'b0}; // LD x5,-2048(x6)
        vecs[14] = '{3'd0, 4'd0, 5'd1,  5'd1,  5'd1,  32'd0,         32'h00000013, 1'b1}; // RTYPE aluop 0
        vecs[15] = '{3'd4, 4'd1, 5'd0,  5'd3,  5'd4,  32'd4094,      32'h7E419FE3, 1'b0}; // BNE x3,x4,4094
        vecs[16] = '{3'd4, 4'd2, 5'd0,  5'd3,  5'd4,  32'd4096,      32'h00000013, 1'b1}; // BLT 4096
        vecs[17] = '{3'd1, 4'd7, 5'd7,  5'd8,  5'd0,  32'd5,         32'h00545393, 1'b0}; // SRLI x7,x8,5

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        in_valid = 1'b0; in_class = '0; in_aluop = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_wr_count", wr_count, 0);

        // Single write, back-to-back, illegal, wrap, mixed table entries.
        run_load(10'h100, 0, 1, 0);
        run_load(10'h100, 1, 4, 0);
        run_load(10'h180, 5, 3, 3);
        run_load(10'h3FC, 10, 2, 0);
        run_load(10'h040, 12, 6, 3);

        // Branch with a two-cycle valid gap.
        do_start(10'h200, 8'd2);
        drive(8);
        @(posedge clk); #1;
        chk("gap_we0", imem_we, 1);
        chk("gap_addr0", imem_addr, 10'h200);
        chk("gap_data0", imem_wdata, 32'hFE208EE3);
        chk("gap_done0", done, 0);
        in_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
            @(posedge clk); #1;
            chk("gap_no_we", imem_we, 0);
            chk("gap_ready", in_ready, 1);
        end
        drive(9);
        @(posedge clk); #1;
        chk("gap_we1", imem_we, 1);
        chk("gap_addr1", imem_addr, 10'h204);
        chk("gap_data1", imem_wdata, 32'h0020D463);
        chk("gap_done1", done, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("gap_busy_end", busy, 0);

        // Start while running is ignored.
        do_start(10'h080, 8'd2);
        start = 1'b1; base_addr = 10'h300; length = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rs_busy", busy, 1);
        chk("rs_no_we", imem_we, 0);
        drive(0);
        @(posedge clk); #1;
        chk("rs_addr0", imem_addr, 10'h080);
        chk("rs_data0", imem_wdata, 32'h002081B3);
        drive(1);
        @(posedge clk); #1;
        chk("rs_addr1", imem_addr, 10'h084);
        chk("rs_data1", imem_wdata, 32'h407302B3);
        chk("rs_done", done, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rs_busy_end", busy, 0);
        chk("rs_wr_count", wr_count, 2);

        // Zero-length start.
        do_start(10'h044, 8'd0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_we", imem_we, 0);
        @(posedge clk); #1;
        chk("len0_done_clear", done, 0);
        chk("len0_we_after", imem_we, 0);
        chk("len0_busy_after", busy, 0);

        // Reset after the second write of a five-word load.
        do_start(10'h010, 8'd5);
        drive(0);
        @(posedge clk); #1;
        chk("rml_addr0", imem_addr, 10'h010);
        drive(1);
        @(posedge clk); #1;
        chk("rml_we1", imem_we, 1);
        chk("rml_addr1", imem_addr, 10'h014);
        drive(2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rml_we_in_rst", imem_we, 0);
        chk("rml_done_in_rst", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rml_busy", busy, 0);
        chk("rml_we", imem_we, 0);
        chk("rml_done", done, 0);
        chk("rml_wr_count", wr_count, 0);
        chk("rml_err_count", err_count, 0);
        chk("rml_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rml_quiet_we", imem_we, 0);
            chk("rml_quiet_done", done, 0);
        end
        run_load(10'h020, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
